// File: rtl/serial_xnor_comparator_pkg.sv
// rtl/serial_xnor_comparator_pkg.sv - shared constants and state encoding for the serial XNOR comparator
package serial_xnor_comparator_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/serial_xnor_comparator_xnor_gate.sv
// rtl/serial_xnor_comparator_xnor_gate.sv - 1-bit XNOR datapath cell
module xnor_gate (
  input  logic A,
  input  logic B,
  output logic C
);

  assign C = ~(A ^ B);

endmodule

// File: rtl/serial_xnor_comparator.sv
// rtl/serial_xnor_comparator.sv - bit-serial word compare sequenced through one shared XNOR cell
module serial_xnor_comparator
  import serial_xnor_comparator_pkg::*;
#(
  parameter  int WIDTH = DEFAULT_WIDTH,
  localparam int CW    = $clog2(WIDTH + 1),
  localparam int IW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             equal,
  output logic [CW-1:0]    match_count,
  output logic [IW-1:0]    mismatch_idx
);

  state_t           state, state_nx;
  logic [WIDTH-1:0] sa, sb;
  logic [IW-1:0]    idx, fm, fm_nx;
  logic [CW-1:0]    cnt, cnt_nx;
  logic             all_eq, all_eq_nx;
  logic             fm_found, fm_found_nx;
  logic             x;
  logic             last_bit;

  xnor_gate u_xnor (
    .A (sa[0]),
    .B (sb[0]),
    .C (x)
  );

  assign last_bit = (idx == IW'(WIDTH - 1));

  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt + CW'(x);
    all_eq_nx   = all_eq & x;
    fm_nx       = fm;
    fm_found_nx = fm_found | ~x;
    // Only the first mismatch in LSB-first order is latched.
    if (!x && !fm_found) begin
      fm_nx = idx;
    end
    case (state)
      ST_IDLE:  if (start) state_nx = ST_SHIFT;
      ST_SHIFT: if (last_bit) state_nx = ST_DONE;
      ST_DONE:  state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
      equal        <= 1'b0;
      match_count  <= '0;
      mismatch_idx <= '0;
      sa           <= '0;
      sb           <= '0;
      idx          <= '0;
      cnt          <= '0;
      all_eq       <= 1'b0;
      fm           <= '0;
      fm_found     <= 1'b0;
    end else begin
      state <= state_nx;
      busy  <= (state_nx != ST_IDLE);
      done  <= (state_nx == ST_DONE);
      case (state)
        ST_IDLE: begin
          if (start) begin
            sa           <= a;
            sb           <= b;
            idx          <= '0;
            cnt          <= '0;
            all_eq       <= 1'b1;
            fm           <= '0;
            fm_found     <= 1'b0;
            equal        <= 1'b0;
            match_count  <= '0;
            mismatch_idx <= '0;
          end
        end
        ST_SHIFT: begin
          sa       <= sa >> 1;
          sb       <= sb >> 1;
          idx      <= idx + IW'(1);
          cnt      <= cnt_nx;
          all_eq   <= all_eq_nx;
          fm       <= fm_nx;
          fm_found <= fm_found_nx;
          // Results are published from the accumulators including the final bit.
          if (last_bit) begin
            equal        <= all_eq_nx;
            match_count  <= cnt_nx;
            mismatch_idx <= fm_nx;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
